// File: rtl/edge_period_sequencer_pkg.sv
// Shared constants for the edge period sequencer: FSM state encoding and default widths.
package edge_period_sequencer_pkg;

    localparam int          DEF_CNT_W   = 24;
    localparam int          DEF_SUM_W   = 32;
    localparam int          DEF_NPER_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 32'd16777215;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARM     = 2'd1;
    localparam state_t ST_MEASURE = 2'd2;
    localparam state_t ST_FINISH  = 2'd3;

endpackage

// File: rtl/edge_period_sequencer_counter.sv
// Per-interval cycle counter: clear, reload to 1 on an edge, otherwise count up and
// stick at the timeout limit so it can never wrap.
module edge_period_sequencer_counter #(
    parameter int          CNT_W   = 24,
    parameter int unsigned TIMEOUT = 32'd16777215
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_one,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= CNT_W'(1);
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/edge_period_sequencer.sv
// Times N consecutive edge-to-edge intervals of the squared input and reports their
// saturated sum, with a timeout when edges stop arriving.
module edge_period_sequencer
    import edge_period_sequencer_pkg::*;
#(
    parameter int          CNT_W   = DEF_CNT_W,
    parameter int          SUM_W   = DEF_SUM_W,
    parameter int          NPER_W  = DEF_NPER_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic [NPER_W-1:0] cfg_num_periods,
    input  logic              rising_edge,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [SUM_W-1:0]  period_sum,
    output logic [NPER_W-1:0] periods_done
);

    // One spare bit above the wider operand so the saturation test sees any carry.
    localparam int               ACC_W   = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
    localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'({SUM_W{1'b1}});

    state_t            state;
    logic [NPER_W-1:0] num_target;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_at_limit;
    logic              cnt_clear;
    logic              cnt_load_one;
    logic              cnt_enable;
    logic [ACC_W-1:0]  sum_wide;
    logic [SUM_W-1:0]  sum_sat;
    logic              last_period;

    edge_period_sequencer_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_counter (
        .sclk     (sclk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .enable   (cnt_enable),
        .cnt      (cnt),
        .at_limit (cnt_at_limit)
    );

    always_comb begin
        cnt_clear    = 1'b0;
        cnt_load_one = 1'b0;
        cnt_enable   = 1'b0;
        case (state)
            ST_IDLE: cnt_clear = start;
            ST_ARM, ST_MEASURE: begin
                cnt_load_one = rising_edge;
                cnt_enable   = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum_wide    = ACC_W'(period_sum) + ACC_W'(cnt);
    assign sum_sat     = (sum_wide > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : sum_wide[SUM_W-1:0];
    assign last_period = ((periods_done + NPER_W'(1)) == num_target);

    // done and busy change on the edge that enters FINISH, so done is high exactly in FINISH.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            period_sum   <= '0;
            periods_done <= '0;
            num_target   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_target   <= (cfg_num_periods == '0) ? NPER_W'(1) : cfg_num_periods;
                        period_sum   <= '0;
                        periods_done <= '0;
                        timeout_err  <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (rising_edge) begin
                        state <= ST_MEASURE;
                    end else if (cnt_at_limit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_MEASURE: begin
                    if (rising_edge) begin
                        period_sum   <= sum_sat;
                        periods_done <= periods_done + NPER_W'(1);
                        if (last_period) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end
                    end else if (cnt_at_limit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_period_sequencer.sv
// Bench for edge_period_sequencer: three differently parameterised instances share one
// stimulus stream and are compared against a table and an edge-list reference model.
module tb_edge_period_sequencer;

    logic       sclk;
    logic       rst;
    logic       start;
    logic [7:0] cfg_num_periods;
    logic       rising_edge;

    logic        busy_a, done_a, err_a;
    logic [31:0] sum_a;
    logic [7:0]  pd_a;
    logic        busy_b, done_b, err_b;
    logic [31:0] sum_b;
    logic [7:0]  pd_b;
    logic        busy_c, done_c, err_c;
    logic [7:0]  sum_c;
    logic [7:0]  pd_c;

    int checks;
    int errors;

    int edge_q[$];
    int got_cyc[3];
    int got_pulses[3];
    int got_err[3];
    longint got_sum[3];
    int got_pd[3];
    int busy_bad[3];

    int     inst_timeout[3];
    longint inst_max[3];
    string  inst_name[3];

    typedef struct {
        int n_cfg; int first; int gap; int ne;
        int err_a; int sum_a; int pd_a;
        int err_b; int sum_b; int pd_b;
        int err_c; int sum_c; int pd_c;
    } vec_t;

    vec_t vecs[11];

    edge_period_sequencer #(.CNT_W(16), .SUM_W(32), .NPER_W(8), .TIMEOUT(200)) dut_a (
        .sclk(sclk), .rst(rst), .start(start), .cfg_num_periods(cfg_num_periods),
        .rising_edge(rising_edge), .busy(busy_a), .done(done_a), .timeout_err(err_a),
        .period_sum(sum_a), .periods_done(pd_a));

    edge_period_sequencer #(.CNT_W(8), .SUM_W(32), .NPER_W(8), .TIMEOUT(50)) dut_b (
        .sclk(sclk), .rst(rst), .start(start), .cfg_num_periods(cfg_num_periods),
        .rising_edge(rising_edge), .busy(busy_b), .done(done_b), .timeout_err(err_b),
        .period_sum(sum_b), .periods_done(pd_b));

    edge_period_sequencer #(.CNT_W(16), .SUM_W(8), .NPER_W(8), .TIMEOUT(200)) dut_c (
        .sclk(sclk), .rst(rst), .start(start), .cfg_num_periods(cfg_num_periods),
        .rising_edge(rising_edge), .busy(busy_c), .done(done_c), .timeout_err(err_c),
        .period_sum(sum_c), .periods_done(pd_c));

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit edge_at(input int k);
        foreach (edge_q[i]) if (edge_q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: walk the list of edge times and apply the interval/timeout rules directly.
    task automatic model(input int t_lim, input longint m_max, input int n_cfg,
                         output int d_cyc, output int err, output longint sum, output int pd);
        int n;
        int prev;
        int gap;
        n = (n_cfg == 0) ? 1 : n_cfg;
        sum = 0; pd = 0; err = 0; d_cyc = -1;
        if (edge_q.size() == 0 || edge_q[0] - 1 > t_lim) begin
            err = 1; d_cyc = t_lim + 1;
            return;
        end
        prev = edge_q[0];
        for (int i = 1; i < edge_q.size(); i++) begin
            gap = edge_q[i] - prev;
            if (gap > t_lim) begin
                err = 1; d_cyc = prev + t_lim;
                return;
            end
            sum = (sum + gap > m_max) ? m_max : sum + gap;
            pd++;
            if (pd == n) begin
                d_cyc = edge_q[i];
                return;
            end
            prev = edge_q[i];
        end
        err = 1; d_cyc = prev + t_lim;
    endtask

    task automatic record(input int idx, input int k, input logic dn, input logic bz,
                          input logic er, input longint sm, input int pdv);
        if (got_pulses[idx] == 0 && !dn && !bz) busy_bad[idx]++;
        if (dn && bz) busy_bad[idx]++;
        if (dn) begin
            got_pulses[idx]++;
            got_cyc[idx] = k;
            got_err[idx] = int'(er);
            got_sum[idx] = sm;
            got_pd[idx]  = pdv;
        end
    endtask

    task automatic apply_stimulus(input int n_cfg, input bit hold);
        int  k;
        int  bound;
        bit  all_done;
        for (int i = 0; i < 3; i++) begin
            got_cyc[i] = -1; got_pulses[i] = 0; got_err[i] = -1;
            got_sum[i] = -1; got_pd[i] = -1; busy_bad[i] = 0;
        end
        bound = ((edge_q.size() > 0) ? edge_q[edge_q.size()-1] : 0) + 260;
        start = 1'b0; rising_edge = 1'b0;
        tick();
        tick();
        cfg_num_periods = 8'(n_cfg);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        cfg_num_periods = 8'($urandom);
        k = 0;
        all_done = 1'b0;
        while (!all_done && k < bound) begin
            k++;
            rising_edge = edge_at(k);
            tick();
            record(0, k, done_a, busy_a, err_a, longint'(sum_a), int'(pd_a));
            record(1, k, done_b, busy_b, err_b, longint'(sum_b), int'(pd_b));
            record(2, k, done_c, busy_c, err_c, longint'(sum_c), int'(pd_c));
            all_done = (got_pulses[0] > 0) && (got_pulses[1] > 0) && (got_pulses[2] > 0);
        end
        rising_edge = 1'b0;
        if (!hold) start = 1'b0;
    endtask

    task automatic check_instance(input string tag, input int idx, input int n_cfg,
                                  input int e_err, input longint e_sum, input int e_pd);
        int d_cyc; int m_err; longint m_sum; int m_pd;
        model(inst_timeout[idx], inst_max[idx], n_cfg, d_cyc, m_err, m_sum, m_pd);
        check_output({tag, "_", inst_name[idx], "_done_cycle"}, got_cyc[idx], d_cyc);
        check_output({tag, "_", inst_name[idx], "_done_pulses"}, got_pulses[idx], 1);
        check_output({tag, "_", inst_name[idx], "_busy_shape"}, busy_bad[idx], 0);
        check_output({tag, "_", inst_name[idx], "_timeout_err"}, got_err[idx], e_err);
        check_output({tag, "_", inst_name[idx], "_period_sum"}, got_sum[idx], e_sum);
        check_output({tag, "_", inst_name[idx], "_periods_done"}, got_pd[idx], e_pd);
    endtask

    task automatic build_edges(input int first, input int gap, input int ne);
        edge_q.delete();
        for (int i = 0; i < ne; i++) edge_q.push_back(first + i * gap);
    endtask

    initial begin
        int pulses;
        int n_cfg; int n_eff; int ne; int t;
        int d_cyc; int m_err; longint m_sum; int m_pd;

        checks = 0; errors = 0;
        inst_timeout[0] = 200; inst_max[0] = 64'd4294967295; inst_name[0] = "A";
        inst_timeout[1] = 50;  inst_max[1] = 64'd4294967295; inst_name[1] = "B";
        inst_timeout[2] = 200; inst_max[2] = 64'd255;        inst_name[2] = "C";

        // n, first, gap, edges | A err,sum,pd | B err,sum,pd | C err,sum,pd
        vecs[0]  = '{4, 1, 100, 5,  0, 400, 4,  1, 0, 0,    0, 255, 4};
        vecs[1]  = '{0, 3, 7, 3,    0, 7, 1,    0, 7, 1,    0, 7, 1};
        vecs[2]  = '{3, 2, 20, 2,   1, 20, 1,   1, 20, 1,   1, 20, 1};
        vecs[3]  = '{3, 5, 100, 4,  0, 300, 3,  1, 0, 0,    0, 255, 3};
        vecs[4]  = '{2, 1, 50, 3,   0, 100, 2,  0, 100, 2,  0, 100, 2};
        vecs[5]  = '{2, 1, 51, 3,   0, 102, 2,  1, 0, 0,    0, 102, 2};
        vecs[6]  = '{3, 1, 1, 4,    0, 3, 3,    0, 3, 3,    0, 3, 3};
        vecs[7]  = '{1, 51, 10, 2,  0, 10, 1,   0, 10, 1,   0, 10, 1};
        vecs[8]  = '{1, 52, 10, 2,  0, 10, 1,   1, 0, 0,    0, 10, 1};
        vecs[9]  = '{1, 1, 1, 0,    1, 0, 0,    1, 0, 0,    1, 0, 0};
        vecs[10] = '{2, 1, 128, 3,  0, 256, 2,  1, 0, 0,    0, 255, 2};

        rst = 1'b1; start = 1'b0; cfg_num_periods = 8'd0; rising_edge = 1'b0;
        tick(); tick(); tick();
        check_output("reset_busy", busy_a | busy_b | busy_c, 0);
        check_output("reset_done", done_a | done_b | done_c, 0);
        check_output("reset_timeout_err", err_a | err_b | err_c, 0);
        check_output("reset_period_sum", sum_a | sum_b | 32'(sum_c), 0);
        check_output("reset_periods_done", pd_a | pd_b | pd_c, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 11; v++) begin
            build_edges(vecs[v].first, vecs[v].gap, vecs[v].ne);
            apply_stimulus(vecs[v].n_cfg, 1'b0);
            check_instance($sformatf("vec%0d", v), 0, vecs[v].n_cfg, vecs[v].err_a, vecs[v].sum_a, vecs[v].pd_a);
            check_instance($sformatf("vec%0d", v), 1, vecs[v].n_cfg, vecs[v].err_b, vecs[v].sum_b, vecs[v].pd_b);
            check_instance($sformatf("vec%0d", v), 2, vecs[v].n_cfg, vecs[v].err_c, vecs[v].sum_c, vecs[v].pd_c);
        end

        // Start held high through a whole run, then through FINISH into the earliest restart.
        build_edges(1, 50, 3);
        apply_stimulus(2, 1'b1);
        for (int i = 0; i < 3; i++) check_instance("hold", i, 2, 0, 100, 2);
        cfg_num_periods = 8'd4;
        tick();
        check_output("start_in_finish_ignored", busy_a | busy_b | busy_c, 0);
        tick();
        check_output("earliest_restart_busy", busy_a & busy_b & busy_c, 1);
        start = 1'b0;

        // Reset mid-MEASURE at cycle 40 of the restarted run.
        for (int j = 1; j <= 40; j++) begin
            rising_edge = (j <= 31) && (j % 10 == 1);
            rst = (j == 40);
            tick();
            if (j == 39) begin
                check_output("pre_reset_periods_done", pd_a, 3);
                check_output("pre_reset_period_sum", sum_b, 30);
            end
        end
        rising_edge = 1'b0;
        rst = 1'b0;
        check_output("abort_busy", busy_a | busy_b | busy_c, 0);
        check_output("abort_period_sum", sum_a | sum_b | 32'(sum_c), 0);
        check_output("abort_periods_done", pd_a | pd_b | pd_c, 0);
        pulses = 0;
        for (int j = 0; j < 300; j++) begin
            rising_edge = (j % 13 == 0);
            tick();
            pulses += int'(done_a) + int'(done_b) + int'(done_c) + int'(busy_a | busy_b | busy_c);
        end
        rising_edge = 1'b0;
        check_output("abort_no_done", pulses, 0);

        for (int r = 0; r < 25; r++) begin
            n_cfg = $urandom_range(0, 5);
            n_eff = (n_cfg == 0) ? 1 : n_cfg;
            ne = $urandom_range(0, n_eff + 2);
            edge_q.delete();
            t = $urandom_range(1, 70);
            for (int i = 0; i < ne; i++) begin
                edge_q.push_back(t);
                t += ($urandom_range(0, 3) == 0) ? $urandom_range(40, 230) : $urandom_range(1, 60);
            end
            apply_stimulus(n_cfg, 1'b0);
            for (int i = 0; i < 3; i++) begin
                model(inst_timeout[i], inst_max[i], n_cfg, d_cyc, m_err, m_sum, m_pd);
                check_instance($sformatf("rand%0d", r), i, n_cfg, m_err, m_sum, m_pd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
